// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg: scheduler state encoding and job offset alignment shared by the job scheduler files
package aes_sched_pkg;
  typedef enum logic [1:0] {IDLE, START, RUN} state_t;
  localparam int OFFSET_ALIGN = 2;
endpackage

// File: rtl/aes_job_fifo.sv
// aes_job_fifo: sync job FIFO; clk/rst, push/pop requests, din in, dout head, full/empty status (extra pointer bit tells them apart)
module aes_job_fifo #(
  parameter int DEPTH = 4,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] mem_q [DEPTH];
  logic [AW-1:0] mem_d [DEPTH];
  logic [PW:0] wp_q, wp_d, rp_q, rp_d;
  logic wr, rd;
  always_comb begin
    full = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
    empty = wp_q == rp_q;
    wr = push && !full;
    rd = pop && !empty;
    dout = mem_q[rp_q[PW-1:0]];
    mem_d = mem_q;
    if (wr) mem_d[wp_q[PW-1:0]] = din;
    wp_d = wp_q + {{PW{1'b0}}, wr};
    rp_d = rp_q + {{PW{1'b0}}, rd};
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    wp_q <= rst ? '0 : wp_d;
    rp_q <= rst ? '0 : rp_d;
  end
endmodule

// File: rtl/aes_job_sched.sv
// aes_job_sched: AES job controller; host job_* queue, core ap_* handshake with data_offset, done_*/jobs_done/busy status, wl_*/host_* to mem_* buffer arbitration
module aes_job_sched
  import aes_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = 4,
  parameter int CNT_W = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             job_vld,
  output logic             job_rdy,
  input  logic [AW-1:0]    job_offset,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic [AW-1:0]    data_offset,
  output logic             done_vld,
  output logic [AW-1:0]    done_offset,
  output logic [CNT_W-1:0] jobs_done,
  output logic             busy,
  input  logic             wl_ce,
  input  logic             wl_we,
  input  logic [AW-1:0]    wl_addr,
  input  logic [7:0]       wl_d,
  input  logic             host_ce,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [7:0]       host_d,
  output logic             host_gnt,
  output logic             host_q_vld,
  output logic             mem_ce,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [7:0]       mem_d,
  input  logic [7:0]       mem_q
);
  state_t state_q, state_d;
  logic [AW-1:0] data_offset_q, data_offset_d, done_offset_q, done_offset_d, fifo_dout;
  logic [CNT_W-1:0] jobs_done_q, jobs_done_d;
  logic done_vld_q, done_vld_d, host_q_vld_q, host_q_vld_d;
  logic full, empty, pop, fin, unused;
  aes_job_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk  (ap_clk),
    .rst  (ap_rst),
    .push (job_vld),
    .pop  (pop),
    .din  (job_offset & ~AW'((1 << OFFSET_ALIGN) - 1)),
    .dout (fifo_dout),
    .full (full),
    .empty(empty)
  );
  always_comb begin
    fin = state_q == RUN && ap_done;
    pop = !empty && (state_q == IDLE || fin);
    state_d = state_q == IDLE  ? (empty ? IDLE : START)
            : state_q == START ? (ap_ready ? RUN : START)
            : fin ? (empty ? IDLE : START) : RUN;
    data_offset_d = pop ? fifo_dout : data_offset_q;
    done_vld_d = fin;
    done_offset_d = fin ? data_offset_q : done_offset_q;
    jobs_done_d = jobs_done_q + CNT_W'(fin);
    host_gnt = !wl_ce && host_ce;
    host_q_vld_d = host_gnt && !host_we;
    mem_ce = wl_ce || host_ce;
    mem_we = wl_ce ? wl_we : host_we;
    mem_addr = wl_ce ? wl_addr : host_addr;
    mem_d = wl_ce ? wl_d : host_d;
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= IDLE;
      data_offset_q <= '0;
      done_vld_q <= 1'b0;
      done_offset_q <= '0;
      jobs_done_q <= '0;
      host_q_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_offset_q <= data_offset_d;
      done_vld_q <= done_vld_d;
      done_offset_q <= done_offset_d;
      jobs_done_q <= jobs_done_d;
      host_q_vld_q <= host_q_vld_d;
    end
  end
  assign unused = ^mem_q;
  assign job_rdy = !full;
  assign ap_start = state_q == START;
  assign busy = state_q != IDLE || !empty;
  assign data_offset = data_offset_q;
  assign done_vld = done_vld_q;
  assign done_offset = done_offset_q;
  assign jobs_done = jobs_done_q;
  assign host_q_vld = host_q_vld_q;
endmodule

// File: tb/tb_aes_job_sched.sv
// tb_aes_job_sched: directed and random stimulus against a queue-based job model with a completion scoreboard
module tb_aes_job_sched;
  localparam int DEPTH = 4;
  localparam int AW = 4;
  localparam int CNT_W = 16;
  logic ap_clk = 0, ap_rst = 1, job_vld = 0, ap_ready = 0, ap_done = 0;
  logic wl_ce = 0, wl_we = 0, host_ce = 0, host_we = 0;
  logic [AW-1:0] job_offset = '0, wl_addr = '0, host_addr = '0;
  logic [7:0] wl_d = '0, host_d = '0, mem_q = '0;
  logic job_rdy, ap_start, done_vld, busy, host_gnt, host_q_vld, mem_ce, mem_we;
  logic [AW-1:0] data_offset, done_offset, mem_addr;
  logic [CNT_W-1:0] jobs_done;
  logic [7:0] mem_d;
  int checks = 0, errors = 0;
  int mst = 0;
  logic [AW-1:0] mfq[$];
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] m_off = '0, m_doff = '0;
  logic m_done = 0, m_hqv = 0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic [AW-1:0] fill_offs [6] = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h0, 4'h8};
  always #5 ap_clk = ~ap_clk;
  aes_job_sched #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .job_vld(job_vld), .job_rdy(job_rdy), .job_offset(job_offset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .data_offset(data_offset),
    .done_vld(done_vld), .done_offset(done_offset), .jobs_done(jobs_done), .busy(busy),
    .wl_ce(wl_ce), .wl_we(wl_we), .wl_addr(wl_addr), .wl_d(wl_d),
    .host_ce(host_ce), .host_we(host_we), .host_addr(host_addr), .host_d(host_d),
    .host_gnt(host_gnt), .host_q_vld(host_q_vld),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic cyc();
    logic fin, pop, acc;
    #1;
    chk("mem_ce", mem_ce, wl_ce || host_ce);
    chk("mem_we", mem_we, wl_ce ? wl_we : host_we);
    chk("mem_addr", mem_addr, wl_ce ? wl_addr : host_addr);
    chk("mem_d", mem_d, wl_ce ? wl_d : host_d);
    chk("host_gnt", host_gnt, !wl_ce && host_ce);
    chk("job_rdy", job_rdy, mfq.size() < DEPTH);
    fin = mst == 2 && ap_done;
    pop = mfq.size() > 0 && (mst == 0 || fin);
    acc = job_vld && mfq.size() < DEPTH;
    if (ap_rst) begin
      mst = 0; mfq.delete(); exp_q.delete();
      m_off = '0; m_doff = '0; m_done = 0; m_cnt = '0; m_hqv = 0;
    end else begin
      m_done = fin;
      if (fin) begin m_doff = m_off; m_cnt++; end
      m_hqv = !wl_ce && host_ce && !host_we;
      mst = mst == 0 ? (pop ? 1 : 0) : mst == 1 ? (ap_ready ? 2 : 1) : fin ? (pop ? 1 : 0) : 2;
      if (pop) m_off = mfq.pop_front();
      if (acc) begin
        mfq.push_back(job_offset & ~AW'(3));
        exp_q.push_back(job_offset & ~AW'(3));
      end
    end
    @(posedge ap_clk);
    #1;
    chk("ap_start", ap_start, mst == 1);
    chk("data_offset", data_offset, m_off);
    chk("done_vld", done_vld, m_done);
    chk("done_offset", done_offset, m_doff);
    chk("jobs_done", jobs_done, m_cnt);
    chk("busy", busy, mst != 0 || mfq.size() > 0);
    chk("host_q_vld", host_q_vld, m_hqv);
  endtask
  always @(negedge ap_clk) begin
    if (done_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_order got=completion exp=no pending job at %0t", $time);
      end else chk("sb_order", done_offset, exp_q.pop_front());
    end
  end
  initial begin
    @(posedge ap_clk);
    repeat (2) cyc();
    ap_rst = 0;
    cyc();
    job_vld = 1; job_offset = 4'h4; cyc();
    job_vld = 0; cyc();
    ap_ready = 1; cyc();
    ap_ready = 0; ap_done = 1; cyc();
    ap_done = 0; cyc();
    foreach (fill_offs[i]) begin
      job_vld = 1; job_offset = fill_offs[i]; cyc();
    end
    job_vld = 0;
    repeat (60) begin
      ap_ready = ($urandom % 2) == 0;
      ap_done = ($urandom % 3) == 0;
      cyc();
    end
    ap_ready = 0; ap_done = 0;
    job_vld = 1; job_offset = 4'h7; cyc();
    job_vld = 0; repeat (3) cyc();
    ap_ready = 1; ap_done = 1; repeat (4) cyc();
    ap_ready = 0; ap_done = 0;
    wl_ce = 1; wl_we = 1; wl_addr = 4'h5; wl_d = 8'hA5;
    host_ce = 1; host_we = 0; host_addr = 4'h3; host_d = 8'h3C; cyc();
    wl_ce = 0; wl_we = 0; cyc();
    host_ce = 0; cyc();
    job_vld = 1; job_offset = 4'h8; cyc();
    job_offset = 4'hC; cyc();
    ap_ready = 1; job_offset = 4'h4; cyc();
    job_vld = 1; job_offset = 4'h0; ap_ready = 0; cyc();
    job_vld = 0; ap_rst = 1; ap_done = 1; cyc();
    ap_rst = 0; ap_done = 0; cyc();
    repeat (800) begin
      ap_rst = ($urandom % 150) == 0;
      job_vld = ($urandom % 2) == 0;
      job_offset = AW'($urandom);
      ap_ready = ($urandom % 3) == 0;
      ap_done = ($urandom % 4) == 0;
      wl_ce = ($urandom % 3) == 0;
      wl_we = ($urandom % 2) == 0;
      wl_addr = AW'($urandom);
      wl_d = 8'($urandom);
      host_ce = ($urandom % 2) == 0;
      host_we = ($urandom % 2) == 0;
      host_addr = AW'($urandom);
      host_d = 8'($urandom);
      cyc();
    end
    ap_rst = 0; job_vld = 0; ap_ready = 0; ap_done = 0; wl_ce = 0; host_ce = 0;
    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
